// File: rtl/nav_pkg.sv
// nav_pkg: shared state type and wrap-around slot search for the cursor navigator
package nav_pkg;
  typedef enum logic [1:0] {NAV_IDLE, NAV_BROWSE, NAV_OFFER} nav_state_t;
  function automatic int next_unmasked(input int idx, input logic [31:0] mask, input int n);
    int r;
    logic [31:0] s;
    r = idx;
    for (int k = 31; k >= 1; k--) begin
      s = mask >> ((idx + k) % n);
      if (k < n && !s[0]) r = (idx + k) % n;
    end
    return r;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on the rising edge of a synchronous level
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic r_q;
  // previous level, updated every cycle regardless of consumer state
  always_ff @(posedge clk or posedge rst)
    if (rst) r_q <= 1'b0;
    else r_q <= level;
  assign rise = level & ~r_q;
endmodule

// File: rtl/cursor_navigator.sv
// cursor_navigator: menu cursor with masked-slot skipping, wrap, auto-select timeout and choice handshake
module cursor_navigator
  import nav_pkg::*;
#(
  parameter int NUM_OPTIONS = 7,
  parameter int TIMEOUT_CYCLES = 500000000,
  localparam int CW = $clog2(NUM_OPTIONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   next,
  input  logic                   select,
  input  logic [NUM_OPTIONS-1:0] option_mask,
  input  logic                   choice_ready,
  output logic                   choice_valid,
  output logic [CW-1:0]          choice,
  output logic [CW-1:0]          cursor,
  output logic                   timeout,
  output logic                   all_blocked,
  output logic                   active
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  nav_state_t r_state, w_state_n;
  logic [CW-1:0] r_cursor, r_choice, w_cursor_n, w_choice_n, w_step, w_first;
  logic [TW-1:0] r_timer, w_timer_n, w_inc;
  logic r_valid, r_timeout, w_valid_n, w_timeout_n;
  logic w_next_rise, w_sel_rise, w_cur_masked, w_fire;
  rise_detect u_next (.clk(clk), .rst(rst), .level(next), .rise(w_next_rise));
  rise_detect u_sel (.clk(clk), .rst(rst), .level(select), .rise(w_sel_rise));
  assign all_blocked = &option_mask;
  assign active = r_state != NAV_IDLE;
  assign choice_valid = r_valid;
  assign choice = r_choice;
  assign cursor = r_cursor;
  assign timeout = r_timeout;
  assign w_step = CW'(next_unmasked(int'(r_cursor), 32'(option_mask), NUM_OPTIONS));
  assign w_first = option_mask[0] ? CW'(next_unmasked(0, 32'(option_mask), NUM_OPTIONS)) : '0;
  assign w_cur_masked = option_mask[r_cursor];
  assign w_fire = (TIMEOUT_CYCLES != 0) && (r_timer >= TLAST);
  assign w_inc = (r_timer == TMAX) ? r_timer : r_timer + TW'(1);
  // next-state logic: select beats step beats auto-advance; timer is cleared when leaving for OFFER so a returning BROWSE starts fresh
  always_comb begin
    w_state_n = r_state;
    w_cursor_n = r_cursor;
    w_choice_n = r_choice;
    w_valid_n = r_valid;
    w_timer_n = r_timer;
    w_timeout_n = 1'b0;
    case (r_state)
      NAV_IDLE: if (enable) begin
        w_state_n = NAV_BROWSE;
        w_cursor_n = w_first;
        w_timer_n = '0;
      end
      NAV_BROWSE:
        if (!enable) w_state_n = NAV_IDLE;
        else if (all_blocked) w_timer_n = '0;
        else if ((w_sel_rise || w_fire) && !w_cur_masked) begin
          w_state_n = NAV_OFFER;
          w_choice_n = r_cursor;
          w_valid_n = 1'b1;
          w_timeout_n = !w_sel_rise;
          w_timer_n = '0;
        end else begin
          w_cursor_n = (w_next_rise || w_cur_masked) ? w_step : r_cursor;
          w_timer_n = (w_next_rise || w_sel_rise) ? '0 : w_inc;
        end
      NAV_OFFER: if (choice_ready) begin
        w_valid_n = 1'b0;
        w_state_n = enable ? NAV_BROWSE : NAV_IDLE;
        w_timer_n = '0;
      end
      default: w_state_n = NAV_IDLE;
    endcase
  end
  // state, cursor, offered choice and timer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= NAV_IDLE;
      r_cursor <= '0;
      r_choice <= '0;
      r_valid <= 1'b0;
      r_timeout <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_n;
      r_cursor <= w_cursor_n;
      r_choice <= w_choice_n;
      r_valid <= w_valid_n;
      r_timeout <= w_timeout_n;
      r_timer <= w_timer_n;
    end
endmodule

// File: tb/tb_cursor_navigator.sv
// tb_cursor_navigator: directed scoreboard bench for cursor_navigator
module tb_cursor_navigator;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, nxt = 1'b0, sel = 1'b0, ready = 1'b0, use_to = 1'b0;
  logic [6:0] mask = '0;
  logic m_valid, m_timeout, m_blocked, m_active, t_valid, t_timeout, t_blocked, t_active;
  logic [2:0] m_choice, m_cursor, t_choice, t_cursor;
  int checks = 0, errors = 0;
  typedef struct {int c; int t;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  cursor_navigator u_main (.clk(clk), .rst(rst), .enable(en & ~use_to), .next(nxt), .select(sel),
    .option_mask(mask), .choice_ready(ready), .choice_valid(m_valid), .choice(m_choice),
    .cursor(m_cursor), .timeout(m_timeout), .all_blocked(m_blocked), .active(m_active));
  cursor_navigator #(.NUM_OPTIONS(7), .TIMEOUT_CYCLES(20)) u_to (.clk(clk), .rst(rst),
    .enable(en & use_to), .next(nxt), .select(sel), .option_mask(mask), .choice_ready(ready),
    .choice_valid(t_valid), .choice(t_choice), .cursor(t_cursor), .timeout(t_timeout),
    .all_blocked(t_blocked), .active(t_active));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input int hold);
    nxt = 1'b1;
    tick(hold);
    nxt = 1'b0;
    tick(1);
  endtask
  task automatic mon(input int c, input int t);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_choice actual=%0d expected=none", c);
    end else begin
      e = q.pop_front();
      chk("sb_choice", c, e.c);
      chk("sb_timeout", t, e.t);
    end
  endtask
  // scoreboard monitor: every accepted choice is compared against the queued expectation
  always @(negedge clk)
    if (!rst) begin
      if (m_valid && ready) mon(int'(m_choice), int'(m_timeout));
      if (t_valid && ready) mon(int'(t_choice), int'(t_timeout));
    end
  initial begin
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_cursor", m_cursor, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_active", m_active, 0);
    chk("rst_blocked", m_blocked, 0);
    en = 1'b1;
    tick(1);
    chk("enter_active", m_active, 1);
    chk("enter_cursor", m_cursor, 0);
    for (int i = 1; i <= 3; i++) begin
      press(5);
      chk("step_cursor", m_cursor, i);
    end
    repeat (3) press(2);
    chk("at_six", m_cursor, 6);
    press(2);
    chk("wrap_zero", m_cursor, 0);
    mask = 7'b0000101;
    tick(1);
    chk("auto_adv", m_cursor, 1);
    press(2);
    chk("skip_to_3", m_cursor, 3);
    repeat (3) press(2);
    press(2);
    chk("wrap_skip_1", m_cursor, 1);
    mask = '0;
    press(2);
    press(2);
    chk("back_to_3", m_cursor, 3);
    q.push_back('{3, 0});
    sel = 1'b1;
    tick(1);
    sel = 1'b0;
    chk("offer_valid", m_valid, 1);
    chk("offer_choice", m_choice, 3);
    repeat (5) begin
      nxt = 1'b1;
      tick(1);
      nxt = 1'b0;
      tick(1);
    end
    chk("hold_choice", m_choice, 3);
    chk("hold_cursor", m_cursor, 3);
    chk("hold_valid", m_valid, 1);
    ready = 1'b1;
    tick(1);
    chk("xfer_valid", m_valid, 0);
    chk("xfer_active", m_active, 1);
    repeat (6) press(2);
    chk("at_two", m_cursor, 2);
    q.push_back('{2, 0});
    nxt = 1'b1;
    sel = 1'b1;
    tick(1);
    chk("both_valid", m_valid, 1);
    chk("both_choice", m_choice, 2);
    chk("both_cursor", m_cursor, 2);
    nxt = 1'b0;
    sel = 1'b0;
    tick(1);
    chk("both_done", m_valid, 0);
    mask = 7'h7F;
    #1;
    chk("all_blocked", m_blocked, 1);
    sel = 1'b1;
    tick(1);
    sel = 1'b0;
    tick(1);
    chk("blk_valid", m_valid, 0);
    chk("blk_cursor", m_cursor, 2);
    mask = 7'b0000100;
    tick(1);
    chk("mask_under", m_cursor, 3);
    mask = '0;
    ready = 1'b0;
    sel = 1'b1;
    tick(1);
    sel = 1'b0;
    chk("pre_rst_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", m_valid, 0);
    chk("async_cursor", m_cursor, 0);
    chk("async_active", m_active, 0);
    tick(1);
    rst = 1'b0;
    use_to = 1'b1;
    ready = 1'b1;
    tick(1);
    chk("to_enter", t_active, 1);
    q.push_back('{0, 1});
    tick(19);
    chk("to_early", t_valid, 0);
    tick(1);
    chk("to_valid", t_valid, 1);
    chk("to_pulse", t_timeout, 1);
    chk("to_choice", t_choice, 0);
    tick(1);
    chk("to_pulse_end", t_timeout, 0);
    tick(9);
    nxt = 1'b1;
    tick(1);
    nxt = 1'b0;
    chk("to_step", t_cursor, 1);
    q.push_back('{1, 1});
    tick(19);
    chk("to_restart", t_valid, 0);
    tick(1);
    chk("to_valid2", t_valid, 1);
    chk("to_choice2", t_choice, 1);
    tick(1);
    mask = 7'h7F;
    tick(30);
    chk("to_blocked", t_valid, 0);
    chk("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
